// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one SRAM read at a time, hands {pc, inst}
// to decode, and picks the next PC from the branch bus at the handoff edge.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  typedef enum logic [1:0] {INIT, REQ, WAIT, FULL} state_t;

  state_t      state_reg;
  logic [31:0] fs_pc_reg;
  logic [31:0] fs_inst_reg;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_next;
  logic        handoff;
  logic [31:0] bus_inst;

  assign br_taken  = br_bus[BR_BUS_WD-1];
  assign br_target = br_bus[31:0];

  // Branch bus only matters at the handoff edge; stale values during a
  // decode stall never reach the PC register.
  assign pc_next = br_taken ? br_target : fs_pc_reg + 32'd4;

  // Request is a pure function of state, so req/addr stay stable until addr_ok.
  assign inst_sram_req  = (state_reg == REQ);
  assign inst_sram_addr = fs_pc_reg;
  assign fs_to_ds_bus   = {fs_pc_reg, bus_inst};

  // Decode-side handshake: bypass SRAM data in WAIT, replay the buffer in FULL.
  always_comb begin
    fs_to_ds_valid = 1'b0;
    handoff        = 1'b0;
    bus_inst       = fs_inst_reg;
    case (state_reg)
      WAIT: begin
        fs_to_ds_valid = inst_sram_data_ok;
        bus_inst       = inst_sram_rdata;
        handoff        = inst_sram_data_ok && ds_allowin;
      end
      FULL: begin
        fs_to_ds_valid = 1'b1;
        handoff        = ds_allowin;
      end
      default: ;
    endcase
  end

  // Fetch FSM with PC and instruction buffer; one outstanding request at most.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= INIT;
      fs_pc_reg   <= RESET_PC;
      fs_inst_reg <= 32'b0;
    end else begin
      case (state_reg)
        INIT: state_reg <= REQ;
        REQ: begin
          if (inst_sram_addr_ok) state_reg <= WAIT;
        end
        WAIT: begin
          if (inst_sram_data_ok) begin
            if (handoff) begin
              state_reg <= REQ;
              fs_pc_reg <= pc_next;
            end else begin
              fs_inst_reg <= inst_sram_rdata;
              state_reg   <= FULL;
            end
          end
        end
        FULL: begin
          if (handoff) begin
            state_reg <= REQ;
            fs_pc_reg <= pc_next;
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural SRAM with adjustable latencies plus a
// transaction-level model of the fetch PC sequence.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference: the PC we expect next, whether a read is in
  // flight, and whether a returned instruction is still waiting for decode.
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  bit          pending;
  bit          held;
  int          req_cnt;
  int          dok_cnt;
  int          aok_lat;
  int          dok_lat;
  bit          rand_lat;
  bit          saw_handoff;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2401_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    exp_pc  = RESET_PC;
    pending = 0;
    held    = 0;
    req_cnt = 0;
    dok_cnt = 0;
  endtask

  // One clock cycle: drive SRAM/decode inputs, check outputs, advance model.
  task automatic tick(input logic allow, input logic [32:0] br);
    logic exp_valid, exp_req, acc, dret, hand;
    @(negedge clk);
    ds_allowin        = allow;
    br_bus            = br;
    inst_sram_addr_ok = inst_sram_req && (req_cnt >= aok_lat);
    inst_sram_data_ok = pending && (dok_cnt >= dok_lat);
    inst_sram_rdata   = inst_sram_data_ok ? mem(pend_addr) : $urandom();
    #1;
    exp_req   = !pending && !held;
    exp_valid = held || inst_sram_data_ok;
    check("req", {63'b0, inst_sram_req}, {63'b0, exp_req});
    if (exp_req) check("req_addr", {32'b0, inst_sram_addr}, {32'b0, exp_pc});
    check("valid", {63'b0, fs_to_ds_valid}, {63'b0, exp_valid});
    if (exp_valid) check("bus", fs_to_ds_bus, {exp_pc, mem(exp_pc)});
    else check("bus_pc", {32'b0, fs_to_ds_bus[63:32]}, {32'b0, exp_pc});
    acc  = inst_sram_addr_ok;
    dret = inst_sram_data_ok;
    hand = exp_valid && allow;
    saw_handoff = hand;
    if (dret) begin
      pending = 0;
      if (rand_lat) aok_lat = $urandom_range(0, 3);
    end else if (pending) dok_cnt++;
    if (acc) begin
      pending   = 1;
      pend_addr = exp_pc;
      dok_cnt   = 0;
      req_cnt   = 0;
      if (rand_lat) dok_lat = $urandom_range(0, 3);
    end else if (exp_req) req_cnt++;
    if (dret && !allow) held = 1;
    if (hand) begin
      held = 0;
      $display("xfer pc=%h inst=%h br=%b/%h", exp_pc, mem(exp_pc), br[32], br[31:0]);
      exp_pc = br[32] ? br[31:0] : exp_pc + 32'd4;
    end
  endtask

  // Asynchronous reset pulse asserted between clock edges.
  task automatic async_reset();
    @(negedge clk);
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_req", {63'b0, inst_sram_req}, 64'd0);
    check("rst_valid", {63'b0, fs_to_ds_valid}, 64'd0);
    check("rst_addr", {32'b0, inst_sram_addr}, {32'b0, RESET_PC});
    check("rst_bus", fs_to_ds_bus, {RESET_PC, 32'b0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("init_req", {63'b0, inst_sram_req}, 64'd0);
    check("init_valid", {63'b0, fs_to_ds_valid}, 64'd0);
    clear_model();
  endtask

  // Stall decode until an instruction is buffered (FULL), bounded.
  task automatic wait_held();
    int k = 0;
    while (!held && k < 60) begin
      tick(1'b0, 33'b0);
      k++;
    end
    check("wait_held_timeout", {63'b0, held}, 64'd1);
  endtask

  // Stall decode until the next request appears, then check its address.
  task automatic next_req_addr(input string tag, input logic [31:0] want);
    int k = 0;
    while (!inst_sram_req && k < 60) begin
      tick(1'b0, 33'b0);
      k++;
    end
    check(tag, {32'b0, inst_sram_addr}, {32'b0, want});
  endtask

  initial begin
    logic [31:0] saved_pc;
    int k;
    aok_lat  = 0;
    dok_lat  = 0;
    rand_lat = 0;
    clear_model();

    // Power-on reset, then zero-wait streaming with decode always ready.
    async_reset();
    check("first_addr", {32'b0, inst_sram_addr}, {32'b0, RESET_PC});
    repeat (8) tick(1'b1, 33'b0);

    // Slow SRAM: addr_ok after 3 cycles, data_ok 4 cycles after acceptance.
    aok_lat = 3;
    dok_lat = 3;
    repeat (20) tick(1'b1, 33'b0);
    aok_lat = 0;
    dok_lat = 0;

    // Decode stall into FULL, stale branch toggling, then untaken handoff.
    wait_held();
    saved_pc = exp_pc;
    repeat (3) tick(1'b0, {1'b1, $urandom()});
    tick(1'b0, 33'b0);
    tick(1'b1, 33'b0);
    next_req_addr("stale_br", saved_pc + 32'd4);

    // Taken branch at the delay-slot handoff.
    wait_held();
    tick(1'b1, {1'b1, 32'hBFC0_0100});
    next_req_addr("br_target", 32'hBFC0_0100);

    // PC wrap: branch to the last word, then fall through modulo 2^32.
    wait_held();
    tick(1'b1, {1'b1, 32'hFFFF_FFFC});
    next_req_addr("br_last", 32'hFFFF_FFFC);
    wait_held();
    tick(1'b1, {1'b0, 32'h1234_5678});
    next_req_addr("wrap", 32'h0000_0000);

    // Randomized traffic.
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 7), {($urandom_range(0, 9) < 3), $urandom()});
    end
    rand_lat = 0;
    aok_lat  = 0;
    dok_lat  = 2;

    // Reset while a read is outstanding.
    k = 0;
    while (!pending && k < 60) begin
      tick(1'b1, 33'b0);
      k++;
    end
    check("pending_timeout", {63'b0, pending}, 64'd1);
    async_reset();
    dok_lat = 0;
    repeat (2) tick(1'b1, 33'b0);
    next_req_addr("post_rst_pc", RESET_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
